// File: rtl/keccak_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keccak_pkg
// Purpose  : Shared constants and types for the Keccak rate-block padder.
// Revision : 1.0 - initial release
// ============================================================================
package keccak_pkg;

    localparam int RATE_BITS  = 576;
    localparam int RATE_WORDS = 18;
    localparam int WORD_W     = 32;
    localparam int CNT_W      = 5;

    // First and closing bytes of the pad10*1 rule
    localparam logic [7:0] PAD_FIRST = 8'h01;
    localparam logic [7:0] PAD_LAST  = 8'h80;

    typedef enum logic [2:0] {
        ABSORB    = 3'd0,
        PAD       = 3'd1,
        FULL      = 3'd2,
        FULL_LAST = 3'd3,
        DONE      = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/keccak_padder_padder1.sv
`default_nettype none
// ============================================================================
// Module   : padder1
// Purpose  : Applies the opening 0x01 pad byte to the final message word.
//            byte_num valid bytes are kept from the top of the word, the
//            next byte becomes 0x01, everything below it is zeroed.
// Revision : 1.0 - initial release
// ============================================================================
module padder1
    import keccak_pkg::*;
(
    input  logic [31:0] in,
    input  logic [1:0]  byte_num,
    output logic [31:0] out
);

    // The lowest byte can never be message data in a padded word
    logic unused_low;
    assign unused_low = ^in[7:0];

    // Keep the valid leading bytes and append the opening pad byte
    always_comb begin
        out = {PAD_FIRST, 24'h000000};
        case (byte_num)
            2'd0:    out = {PAD_FIRST, 24'h000000};
            2'd1:    out = {in[31:24], PAD_FIRST, 16'h0000};
            2'd2:    out = {in[31:16], PAD_FIRST, 8'h00};
            default: out = {in[31:8], PAD_FIRST};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/keccak_padder.sv
`default_nettype none
// ============================================================================
// Module   : keccak_padder
// Purpose  : Packs 32-bit message words into 576-bit rate blocks, applies
//            pad10*1 to the end of the message and hands full blocks to the
//            permutation, holding each block until it is acknowledged.
// Revision : 1.0 - initial release
// ============================================================================
module keccak_padder #(
    parameter int WORD_W     = 32,
    parameter int RATE_WORDS = 18
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [WORD_W-1:0]            in,
    input  logic                         in_ready,
    input  logic                         is_last,
    input  logic [1:0]                   byte_num,
    output logic                         buffer_full,
    output logic [WORD_W*RATE_WORDS-1:0] out,
    input  logic                         f_ack,
    output logic                         buffer_ready
);

    import keccak_pkg::*;

    localparam logic [CNT_W-1:0]  LAST_SLOT  = CNT_W'(RATE_WORDS - 1);
    localparam logic [WORD_W-1:0] CLOSE_WORD = {{(WORD_W-8){1'b0}}, PAD_LAST};
    localparam int                KEEP_W     = WORD_W * (RATE_WORDS - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] padded_word;
    logic [WORD_W-1:0] absorb_word;
    logic [WORD_W-1:0] fill_word;
    logic              last_slot;

    padder1 u_padder1 (
        .in       (in),
        .byte_num (byte_num),
        .out      (padded_word)
    );

    assign last_slot = (cnt == LAST_SLOT);

    // Select the word entering the block; the closing 0x80 lands in slot 18
    always_comb begin
        absorb_word = is_last ? padded_word : in;
        if (is_last && last_slot) begin
            absorb_word = absorb_word | CLOSE_WORD;
        end
        fill_word = last_slot ? CLOSE_WORD : '0;
    end

    // Block assembly FSM: absorb, zero-fill after the last word, hand off
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ABSORB;
            cnt          <= '0;
            out          <= '0;
            buffer_full  <= 1'b0;
            buffer_ready <= 1'b1;
        end else begin
            case (state)
                ABSORB: begin
                    if (in_ready && buffer_ready) begin
                        out <= {out[KEEP_W-1:0], absorb_word};
                        cnt <= cnt + 5'd1;
                        if (last_slot) begin
                            buffer_full  <= 1'b1;
                            buffer_ready <= 1'b0;
                            state        <= is_last ? FULL_LAST : FULL;
                        end else if (is_last) begin
                            buffer_ready <= 1'b0;
                            state        <= PAD;
                        end
                    end
                end
                PAD: begin
                    out <= {out[KEEP_W-1:0], fill_word};
                    cnt <= cnt + 5'd1;
                    if (last_slot) begin
                        buffer_full <= 1'b1;
                        state       <= FULL_LAST;
                    end
                end
                FULL: begin
                    if (f_ack) begin
                        buffer_full  <= 1'b0;
                        buffer_ready <= 1'b1;
                        cnt          <= '0;
                        state        <= ABSORB;
                    end
                end
                FULL_LAST: begin
                    if (f_ack) begin
                        buffer_full <= 1'b0;
                        cnt         <= '0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    buffer_full  <= 1'b0;
                    buffer_ready <= 1'b0;
                end
                default: begin
                    state <= ABSORB;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keccak_padder.sv
`default_nettype none
// ============================================================================
// Module   : tb_keccak_padder
// Purpose  : Self-checking bench for keccak_padder. Expected blocks come from
//            a byte-level pad10*1 model of the whole message.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keccak_padder;

    logic         clk;
    logic         reset_n;
    logic [31:0]  din;
    logic         in_ready;
    logic         is_last;
    logic [1:0]   byte_num;
    logic         buffer_full;
    logic [575:0] dout;
    logic         f_ack;
    logic         buffer_ready;

    int checks;
    int errors;

    logic [7:0]   msg[$];
    logic [575:0] exp_q[$];

    keccak_padder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in           (din),
        .in_ready     (in_ready),
        .is_last      (is_last),
        .byte_num     (byte_num),
        .buffer_full  (buffer_full),
        .out          (dout),
        .f_ack        (f_ack),
        .buffer_ready (buffer_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [575:0] act, input logic [575:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Byte-level model: message, 0x01, zeros to a 72-byte multiple, 0x80 on last byte
    task automatic build_blocks();
        logic [7:0]   p[$];
        logic [575:0] b;
        p = msg;
        p.push_back(8'h01);
        while ((p.size() % 72) != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] | 8'h80;
        for (int blk = 0; blk < p.size() / 72; blk++) begin
            b = '0;
            for (int i = 0; i < 72; i++) b[575-8*i -: 8] = p[blk*72 + i];
            exp_q.push_back(b);
        end
    endtask

    task automatic do_reset();
        in_ready = 1'b0; is_last = 1'b0; byte_num = 2'd0; f_ack = 1'b0; din = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 576'(buffer_ready), 576'd1);
        chk("reset_full",  576'(buffer_full),  576'd0);
        chk("reset_out",   dout, '0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_ready", 576'(buffer_ready), 576'd1);
    endtask

    // Present a word until it is taken; acknowledges a full block while waiting
    task automatic send_word(input logic [31:0] w, input logic last, input logic [1:0] bn);
        bit taken;
        int n;
        taken = 1'b0;
        n = 0;
        din = w; is_last = last; byte_num = bn; in_ready = 1'b1;
        while (!taken && n < 200) begin
            @(negedge clk);
            taken = buffer_ready;
            if (!buffer_ready && buffer_full) f_ack = 1'b1;
            @(posedge clk);
            #1;
            f_ack = 1'b0;
            n++;
        end
        in_ready = 1'b0; is_last = 1'b0;
        if (!taken) begin
            checks++; errors++;
            $display("FAIL word_accept_timeout: got no accept expected accept within 200 cycles");
        end
    endtask

    task automatic send_message(input logic [31:0] fill);
        int len, nfull, rem;
        logic [31:0] w;
        len = msg.size();
        nfull = len / 4;
        rem = len % 4;
        build_blocks();
        for (int k = 0; k < nfull; k++) begin
            w = {msg[4*k], msg[4*k+1], msg[4*k+2], msg[4*k+3]};
            send_word(w, 1'b0, 2'd0);
        end
        w = fill;
        for (int j = 0; j < rem; j++) w[31-8*j -: 8] = msg[4*nfull + j];
        send_word(w, 1'b1, 2'(rem));
    endtask

    task automatic wait_full(output int n);
        n = 0;
        while (!buffer_full && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!buffer_full) begin
            checks++; errors++;
            $display("FAIL full_timeout: got buffer_full=0 expected 1 within 100 cycles");
        end
    endtask

    task automatic ack();
        @(negedge clk);
        f_ack = 1'b1;
        @(posedge clk);
        #1;
        f_ack = 1'b0;
    endtask

    // Compare every newly presented block with the model and hold it stable
    initial begin
        logic         prev_full;
        logic [575:0] held;
        logic [575:0] e;
        prev_full = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_full = 1'b0;
            end else begin
                if (buffer_full && !prev_full) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_block: got %0h expected no block", dout);
                    end else begin
                        e = exp_q.pop_front();
                        chk("block", dout, e);
                    end
                    held = dout;
                end else if (buffer_full) begin
                    chk("block_held", dout, held);
                end
                if (buffer_full) chk("ready_while_full", 576'(buffer_ready), 576'd0);
                prev_full = buffer_full;
            end
        end
    end

    initial begin
        int n;
        checks = 0;
        errors = 0;
        reset_n = 1'b1;
        in_ready = 1'b0; is_last = 1'b0; byte_num = 2'd0; f_ack = 1'b0; din = '0;

        // Full 18-word block, held input during FULL, then the pad-only block
        do_reset();
        msg.delete();
        for (int k = 1; k <= 18; k++) begin
            msg.push_back(8'h00); msg.push_back(8'h00);
            msg.push_back(8'h00); msg.push_back(8'(k));
        end
        build_blocks();
        for (int k = 1; k <= 18; k++) send_word(32'(k), 1'b0, 2'd0);
        chk("b1_full_latency", 576'(buffer_full), 576'd1);
        chk("b1_first_word", 576'(dout[575:544]), 576'h00000001);
        chk("b1_last_word",  576'(dout[31:0]),    576'h00000012);
        chk("b1_ready",      576'(buffer_ready),  576'd0);
        din = 32'hDEADBEEF; is_last = 1'b1; byte_num = 2'd0; in_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("b1_stalled_out", 576'(dout[31:0]), 576'h00000012);
        ack();
        chk("b1_ack_full",  576'(buffer_full),  576'd0);
        chk("b1_ack_ready", 576'(buffer_ready), 576'd1);
        @(posedge clk);
        #1;
        in_ready = 1'b0; is_last = 1'b0;
        chk("b2_pad_ready", 576'(buffer_ready), 576'd0);
        wait_full(n);
        chk("b2_pad_cycles", 576'(n), 576'd17);
        chk("b2_first_word", 576'(dout[575:544]), 576'h01000000);
        chk("b2_last_word",  576'(dout[31:0]),    576'h00000080);
        ack();
        repeat (3) @(posedge clk);
        #1;
        chk("done_ready", 576'(buffer_ready), 576'd0);
        chk("done_full",  576'(buffer_full),  576'd0);

        // Stray f_ack, then a two-byte message
        do_reset();
        ack();
        chk("stray_ack_ready", 576'(buffer_ready), 576'd1);
        chk("stray_ack_full",  576'(buffer_full),  576'd0);
        msg.delete();
        msg.push_back(8'h11); msg.push_back(8'h22);
        send_message(32'h11223344);
        wait_full(n);
        chk("short_pad_cycles", 576'(n), 576'd17);
        chk("short_first_word", 576'(dout[575:544]), 576'h11220100);
        chk("short_mid_zero",   576'(dout[543:32]),  576'd0);
        chk("short_last_word",  576'(dout[31:0]),    576'h00000080);
        ack();
        #1;
        chk("short_done_ready", 576'(buffer_ready), 576'd0);

        // Asynchronous reset in the middle of padding
        do_reset();
        msg.delete();
        msg.push_back(8'h5A);
        send_message(32'h5A000000);
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_ready", 576'(buffer_ready), 576'd1);
        chk("async_reset_full",  576'(buffer_full),  576'd0);
        chk("async_reset_out",   dout, '0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Empty message
        do_reset();
        msg.delete();
        send_message(32'hA5A5A5A5);
        wait_full(n);
        chk("empty_first_word", 576'(dout[575:544]), 576'h01000000);
        chk("empty_last_word",  576'(dout[31:0]),    576'h00000080);
        ack();

        // 71-byte message: both pad bits share the final byte
        do_reset();
        msg.delete();
        for (int i = 0; i < 68; i++) msg.push_back(8'(i * 7 + 3));
        msg.push_back(8'hAA); msg.push_back(8'hBB); msg.push_back(8'hCC);
        send_message(32'hAABBCCDD);
        wait_full(n);
        chk("shared_byte_latency", 576'(n), 576'd0);
        chk("shared_byte_word", 576'(dout[31:0]), 576'hAABBCC81);
        ack();

        // Longer messages spanning blocks
        do_reset();
        msg.delete();
        for (int i = 0; i < 100; i++) msg.push_back(8'(i * 13 + 1));
        send_message(32'h0BADF00D);
        wait_full(n);
        ack();
        do_reset();
        msg.delete();
        for (int i = 0; i < 37; i++) msg.push_back(8'(255 - i));
        send_message(32'hC0FFEE00);
        wait_full(n);
        ack();

        repeat (2) @(posedge clk);
        chk("all_blocks_seen", 576'(exp_q.size()), 576'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
